// File: rtl/spi_flash_read_seq.sv
// Serial-flash READ sequencer: pushes cmd/address/dummy bytes to the SPI TX FIFO,
// drains RX echoes and returns data bytes. Define SPI_FAST_READ_EN for FAST READ (0x0B).
module spi_flash_read_seq #(
    parameter logic [7:0]  READ_CMD        = 8'h03,
    parameter int unsigned ADDR_BYTES      = 3,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic [7:0]  req_len_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [7:0]  rsp_data_o,
    output logic        rsp_last_o,
    input  logic        tx_fifo_full_i,
    output logic        tx_fifo_write_o,
    output logic [7:0]  tx_fifo_data_o,
    input  logic        rx_fifo_empty_i,
    output logic        rx_fifo_read_o,
    input  logic [7:0]  rx_fifo_data_i,
    input  logic        spi_busy_i,
    output logic [1:0]  spi_cs_mode_o,
    output logic        seq_busy_o
);

    localparam int unsigned AddrW = ADDR_BYTES * 8;
`ifdef SPI_FAST_READ_EN
    localparam logic [7:0] CmdByte = 8'h0B;
    localparam logic [8:0] HdrLen  = 9'(ADDR_BYTES + 2);
`else
    localparam logic [7:0] CmdByte = READ_CMD;
    localparam logic [8:0] HdrLen  = 9'(ADDR_BYTES + 1);
`endif
    localparam logic [3:0] MaxOut  = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {StIdle, StRun, StClose} state_e;

    state_e           state_q, state_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic [8:0]       total_q, total_d;
    logic [8:0]       tx_cnt_q, tx_cnt_d;
    logic [8:0]       rx_cnt_q, rx_cnt_d;
    logic [3:0]       outst_q, outst_d;
    logic             tx_write_q, tx_write_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_last_q, rsp_last_d;
    logic [7:0]       rsp_data_q, rsp_data_d;

    logic       push, pop, rsp_hs;
    logic [7:0] tx_byte;
    logic [8:0] req_len9;
    logic       unused_addr;

    assign unused_addr = ^req_addr_i;
    assign req_len9    = (req_len_i == 8'd0) ? 9'd256 : {1'b0, req_len_i};

    // Byte for the current TX index: command, address MSB first, then dummies.
    always_comb begin
        tx_byte = 8'h00;
        if (tx_cnt_q == 9'd0) begin
            tx_byte = CmdByte;
        end
        for (int unsigned i = 1; i <= ADDR_BYTES; i++) begin
            if (tx_cnt_q == 9'(i)) begin
                tx_byte = addr_q[(ADDR_BYTES - i) * 8 +: 8];
            end
        end
    end

    assign push   = (state_q == StRun) && (tx_cnt_q < total_q) && !tx_fifo_full_i &&
                    (outst_q < MaxOut);
    // Header echoes never wait on the response register; data bytes need a free slot.
    assign pop    = (state_q == StRun) && !rx_fifo_empty_i && (rx_cnt_q < total_q) &&
                    ((rx_cnt_q < HdrLen) || !rsp_valid_q || rsp_ready_i);
    assign rsp_hs = rsp_valid_q && rsp_ready_i;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        total_d     = total_q;
        tx_cnt_d    = tx_cnt_q;
        rx_cnt_d    = rx_cnt_q;
        outst_d     = outst_q;
        tx_write_d  = push;
        tx_data_d   = tx_data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_last_d  = rsp_last_q;
        rsp_data_d  = rsp_data_q;

        if (push) begin
            tx_data_d = tx_byte;
            tx_cnt_d  = tx_cnt_q + 9'd1;
        end
        if (pop) begin
            rx_cnt_d = rx_cnt_q + 9'd1;
        end
        unique case ({push, pop})
            2'b10:   outst_d = outst_q + 4'd1;
            2'b01:   outst_d = outst_q - 4'd1;
            default: outst_d = outst_q;
        endcase

        if (pop && (rx_cnt_q >= HdrLen)) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rx_fifo_data_i;
            rsp_last_d  = (rx_cnt_q == total_q - 9'd1);
        end else if (rsp_hs) begin
            rsp_valid_d = 1'b0;
            rsp_last_d  = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    addr_d   = req_addr_i[AddrW-1:0];
                    total_d  = HdrLen + req_len9;
                    tx_cnt_d = 9'd0;
                    rx_cnt_d = 9'd0;
                    outst_d  = 4'd0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (rsp_hs && rsp_last_q) begin
                    state_d = StClose;
                end
            end
            StClose: begin
                if (!spi_busy_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            total_q     <= 9'd0;
            tx_cnt_q    <= 9'd0;
            rx_cnt_q    <= 9'd0;
            outst_q     <= 4'd0;
            tx_write_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            total_q     <= total_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            outst_q     <= outst_d;
            tx_write_q  <= tx_write_d;
            tx_data_q   <= tx_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready_o     = (state_q == StIdle);
    assign seq_busy_o      = (state_q != StIdle);
    assign spi_cs_mode_o   = (state_q == StRun) ? 2'b10 : 2'b00;
    assign tx_fifo_write_o = tx_write_q;
    assign tx_fifo_data_o  = tx_data_q;
    assign rx_fifo_read_o  = pop;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_data_o      = rsp_data_q;
    assign rsp_last_o      = rsp_last_q;

endmodule

// File: tb/tb_spi_flash_read_seq.sv
// Randomized bench for spi_flash_read_seq: loopback FIFO model plus transaction scoreboard.
module tb_spi_flash_read_seq;

    localparam int unsigned AddrBytes = 3;
    localparam int unsigned MaxOut    = 4;
`ifdef SPI_FAST_READ_EN
    localparam int unsigned Hdr = AddrBytes + 2;
    localparam logic [7:0]  Cmd = 8'h0B;
`else
    localparam int unsigned Hdr = AddrBytes + 1;
    localparam logic [7:0]  Cmd = 8'h03;
`endif

    logic        clk, rst_n;
    logic        req_valid_i, req_ready_o;
    logic [31:0] req_addr_i;
    logic [7:0]  req_len_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_last_o;
    logic [7:0]  rsp_data_o;
    logic        tx_fifo_full_i, tx_fifo_write_o;
    logic [7:0]  tx_fifo_data_o;
    logic        rx_fifo_empty_i, rx_fifo_read_o;
    logic [7:0]  rx_fifo_data_i;
    logic        spi_busy_i, seq_busy_o;
    logic [1:0]  spi_cs_mode_o;

    spi_flash_read_seq #(
        .READ_CMD        (8'h03),
        .ADDR_BYTES      (AddrBytes),
        .MAX_OUTSTANDING (MaxOut)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_addr_i      (req_addr_i),
        .req_len_i       (req_len_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_data_o      (rsp_data_o),
        .rsp_last_o      (rsp_last_o),
        .tx_fifo_full_i  (tx_fifo_full_i),
        .tx_fifo_write_o (tx_fifo_write_o),
        .tx_fifo_data_o  (tx_fifo_data_o),
        .rx_fifo_empty_i (rx_fifo_empty_i),
        .rx_fifo_read_o  (rx_fifo_read_o),
        .rx_fifo_data_i  (rx_fifo_data_i),
        .spi_busy_i      (spi_busy_i),
        .spi_cs_mode_o   (spi_cs_mode_o),
        .seq_busy_o      (seq_busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] rx_q[$];   // bytes visible in the RX FIFO
    logic [7:0] fly_q[$];  // bytes still shifting on the wire
    int         fly_t[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready_o, 1);
        check({tag, "_rsp_valid"}, rsp_valid_o, 0);
        check({tag, "_rsp_last"}, rsp_last_o, 0);
        check({tag, "_rsp_data"}, rsp_data_o, 0);
        check({tag, "_tx_write"}, tx_fifo_write_o, 0);
        check({tag, "_tx_data"}, tx_fifo_data_o, 0);
        check({tag, "_rx_read"}, rx_fifo_read_o, 0);
        check({tag, "_cs_mode"}, spi_cs_mode_o, 2'b00);
        check({tag, "_seq_busy"}, seq_busy_o, 0);
    endtask

    // ready_mode: 0 always, 1 random, 2 stall 50 cycles after 2 responses.
    // full_mode: 0 never, 1 toggle every cycle, 2 random. rst_after: reset after N responses.
    task automatic run_req(input logic [31:0] addr, input logic [7:0] len_raw,
                           input int ready_mode, input int full_mode, input int rst_after);
        logic [7:0] exp_tx[$];
        logic [7:0] exp_rsp[$];
        logic [7:0] base, prev_data;
        logic       prev_full, prev_stall, prev_busy, done;
        int         len, total, n_tx, n_pop, n_rsp, outst, stall, busy_tail, budget;

        len   = (len_raw == 8'd0) ? 256 : int'(len_raw);
        total = Hdr + len;
        base  = (ready_mode == 0 && full_mode == 0) ? 8'hA0 : 8'($urandom);
        n_tx = 0; n_pop = 0; n_rsp = 0; outst = 0; stall = 0; busy_tail = 0;
        prev_full = 1'b0; prev_stall = 1'b0; prev_busy = 1'b1; done = 1'b0;
        prev_data = 8'h00;
        budget = 6000;

        exp_tx.push_back(Cmd);
        for (int i = int'(AddrBytes) - 1; i >= 0; i--) exp_tx.push_back(addr[i*8 +: 8]);
        while (exp_tx.size() < total) exp_tx.push_back(8'h00);

        @(negedge clk);
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        req_len_i   = len_raw;
        #1;
        check("req_ready_idle", req_ready_o, 1);
        @(negedge clk);
        req_valid_i = 1'b0;
        req_addr_i  = $urandom;
        req_len_i   = 8'($urandom);
        #1;
        check("tx_after_accept", tx_fifo_write_o, 0);
        check("busy_after_accept", seq_busy_o, 1);
        check("ready_after_accept", req_ready_o, 0);

        forever begin
            rx_fifo_empty_i = (rx_q.size() == 0);
            rx_fifo_data_i  = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
            case (full_mode)
                1:       tx_fifo_full_i = cyc[0];
                2:       tx_fifo_full_i = ($urandom_range(0, 2) == 0);
                default: tx_fifo_full_i = 1'b0;
            endcase
            case (ready_mode)
                1:       rsp_ready_i = ($urandom_range(0, 2) != 0);
                2:       rsp_ready_i = !(n_rsp >= 2 && stall < 50);
                default: rsp_ready_i = 1'b1;
            endcase
            if (!rsp_ready_i && ready_mode == 2) stall++;
            spi_busy_i = !done || (busy_tail > 0);
            #1;

            if (done && req_ready_o) begin
                check("close_waits_busy", prev_busy, 0);
                check("idle_busy", seq_busy_o, 0);
                check("tx_count", n_tx, total);
                check("pop_count", n_pop, total);
                check("rsp_count", n_rsp, len);
                break;
            end
            check("cs_mode", spi_cs_mode_o, done ? 2'b00 : 2'b10);
            if (done) check("no_tx_in_close", tx_fifo_write_o, 0);

            // Strobe seen now was decided on the previous cycle's full flag.
            if (tx_fifo_write_o) begin
                check("push_while_full", prev_full, 0);
                if (n_tx < total) check("tx_data", tx_fifo_data_o, exp_tx[n_tx]);
                else check("tx_overrun", n_tx, total);
                fly_q.push_back(8'(base + n_tx));
                fly_t.push_back(cyc + $urandom_range(1, 3));
                if (n_tx >= int'(Hdr)) exp_rsp.push_back(8'(base + n_tx));
                n_tx++;
                outst++;
            end
            if (rsp_valid_o && !rsp_ready_i) check("pop_during_stall", rx_fifo_read_o, 0);
            if (prev_stall) begin
                check("rsp_hold_valid", rsp_valid_o, 1);
                check("rsp_hold_data", rsp_data_o, prev_data);
            end
            if (rx_fifo_read_o) begin
                check("pop_when_empty", rx_fifo_empty_i, 0);
                if (rx_q.size() > 0) void'(rx_q.pop_front());
                n_pop++;
                outst--;
            end
            check("outst_cap", (outst <= int'(MaxOut)), 1);
            if (rsp_valid_o && rsp_ready_i) begin
                if (n_rsp < exp_rsp.size()) check("rsp_data", rsp_data_o, exp_rsp[n_rsp]);
                else check("rsp_unexpected", n_rsp, exp_rsp.size());
                check("rsp_last", rsp_last_o, (n_rsp == len - 1));
                n_rsp++;
                if (n_rsp == len) begin
                    done = 1'b1;
                    busy_tail = $urandom_range(0, 5);
                end
            end

            prev_full  = tx_fifo_full_i;
            prev_stall = rsp_valid_o && !rsp_ready_i;
            prev_data  = rsp_data_o;
            prev_busy  = spi_busy_i;
            if (done && busy_tail > 0 && spi_busy_i) busy_tail--;
            while (fly_q.size() > 0 && fly_t[0] <= cyc) begin
                rx_q.push_back(fly_q.pop_front());
                void'(fly_t.pop_front());
            end
            cyc++;

            if (rst_after > 0 && n_rsp == rst_after) begin
                @(posedge clk);
                #3;
                rst_n = 1'b0;
                #1;
                check_reset_outputs("midrst");
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                rx_q.delete();
                fly_q.delete();
                fly_t.delete();
                rx_fifo_empty_i = 1'b1;
                break;
            end
            budget--;
            if (budget == 0) begin
                check("timeout", 0, 1);
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid_i = 1'b0; req_addr_i = '0; req_len_i = '0;
        rsp_ready_i = 1'b0; tx_fifo_full_i = 1'b0;
        rx_fifo_empty_i = 1'b1; rx_fifo_data_i = '0; spi_busy_i = 1'b0;
        #1;
        check_reset_outputs("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_req(32'h0001_2345, 8'd4, 0, 0, 0);
        run_req($urandom, 8'd0, 1, 2, 0);
        run_req($urandom, 8'd20, 2, 0, 0);
        run_req($urandom, 8'd12, 0, 1, 0);
        run_req($urandom, 8'd10, 1, 2, 3);
        run_req($urandom, 8'd1, 1, 1, 0);
        for (int k = 0; k < 8; k++) begin
            run_req($urandom, 8'($urandom_range(1, 40)), $urandom_range(0, 1),
                    $urandom_range(0, 2), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
